// File: rtl/pingpong_frame_writer.sv
// Fill stage for the ping-pong feature buffer: packs a valid/ready word stream into
// buffer addresses 0..FRAME_LEN-1, then parks the address at 0 for a guard window.
// Optional macro PINGPONG_WR_PAD_EN zero-pads short frames up to FRAME_LEN-1.
module pingpong_frame_writer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int FRAME_LEN = 256,
  parameter int GUARD_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              wr_we,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              err_short,
  output logic              err_long,
  input  logic              err_clr
);

  localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_GUARD, ST_PAD} state_e;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_e            state_q, state_d;
  wr_t               wr_q, wr_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              live_q;
  logic              done_q, done_d;
  logic              es_q, es_d, el_q, el_d;
  logic              accept, at_last, set_short, set_long;

  // live_q keeps s_ready low while in reset; it rises on the first edge after release.
  assign s_ready = live_q && (state_q == ST_IDLE || state_q == ST_FILL);
  assign accept  = s_valid && s_ready;
  assign at_last = (k_q == LAST_K);

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    wr_d.en   = 1'b0;
    k_d       = k_q;
    gcnt_d    = gcnt_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    case (state_q)
      // k_q is always 0 in IDLE, so IDLE and FILL share the write path.
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          wr_d.en   = 1'b1;
          wr_d.addr = k_q;
          wr_d.data = s_data;
          k_d       = k_q + 1'b1;
          state_d   = ST_FILL;
          if (s_last || at_last) begin
            set_short = s_last && !at_last;
            set_long  = !s_last && at_last;
            state_d   = ST_GUARD;
            done_d    = 1'b1;
            cnt_d     = cnt_q + 16'd1;
            gcnt_d    = '0;
            k_d       = '0;
`ifdef PINGPONG_WR_PAD_EN
            if (set_short) begin
              state_d = ST_PAD;
              done_d  = 1'b0;
              cnt_d   = cnt_q;
              k_d     = k_q + 1'b1;
            end
`endif
          end
        end
      end
`ifdef PINGPONG_WR_PAD_EN
      ST_PAD: begin
        wr_d.en   = 1'b1;
        wr_d.addr = k_q;
        wr_d.data = '0;
        if (at_last) begin
          state_d = ST_GUARD;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          gcnt_d  = '0;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
`endif
      // First GUARD cycle still shows the final write; GUARD_CYC cycles at addr 0 follow.
      ST_GUARD: begin
        wr_d.addr = '0;
        gcnt_d    = gcnt_q + 1'b1;
        if (gcnt_q == GW'(GUARD_CYC)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    es_d = set_short | (es_q & ~err_clr);
    el_d = set_long  | (el_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      k_q     <= '0;
      gcnt_q  <= '0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
      done_q  <= 1'b0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      k_q     <= k_d;
      gcnt_q  <= gcnt_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      done_q  <= done_d;
      es_q    <= es_d;
      el_q    <= el_d;
    end
  end

  assign wr_addr    = wr_q.addr;
  assign wr_data    = wr_q.data;
  assign wr_en      = wr_q.en;
  assign wr_we      = wr_q.en;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;
  assign err_short  = es_q;
  assign err_long   = el_q;

endmodule

// File: tb/tb_pingpong_frame_writer.sv
// Randomized bench for pingpong_frame_writer against a frame-level reference model.
module tb_pingpong_frame_writer;
  localparam int DW = 32, AW = 11, FL = 256, G = 3;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          s_valid = 1'b0, s_last = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, wr_en, wr_we, frame_done, err_short, err_long;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  pingpong_frame_writer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL), .GUARD_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_we(wr_we),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_short(err_short),
    .err_long(err_long), .err_clr(err_clr));

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word index in frame, cycles of backpressure left, pad words left.
  bit          live;
  int          widx, busy, pad_left;
  bit          m_wen, m_done, m_es, m_el;
  logic [31:0] m_addr, m_data;
  logic [15:0] m_cnt;

  function automatic bit m_ready();
    return live && busy == 0 && pad_left == 0;
  endfunction

  task automatic mdl_reset();
    live = 0; widx = 0; busy = 0; pad_left = 0;
    m_wen = 0; m_done = 0; m_es = 0; m_el = 0;
    m_addr = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic frame_close();
    m_done = 1; m_cnt = m_cnt + 16'd1; busy = G + 1; widx = 0;
  endtask

  task automatic mdl_edge(input bit v, input logic [31:0] d, input bit l, input bit clr);
    bit ss = 0, sl = 0, shrt;
    m_wen = 0; m_done = 0;
    if (!live) live = 1;
    else if (pad_left > 0) begin
      m_wen = 1; m_addr = widx; m_data = 0; pad_left--;
      if (pad_left == 0) frame_close(); else widx++;
    end else if (busy > 0) begin
      busy--; m_addr = 0;
    end else if (v) begin
      m_wen = 1; m_addr = widx; m_data = d;
      if (l || widx == FL - 1) begin
        shrt = l && widx < FL - 1;
        ss = shrt; sl = !l;
`ifdef PINGPONG_WR_PAD_EN
        if (shrt) begin pad_left = FL - 1 - widx; widx++; end
        else frame_close();
`else
        frame_close();
`endif
      end else widx++;
    end
    m_es = ss | (m_es & !clr);
    m_el = sl | (m_el & !clr);
  endtask

  task automatic check_outputs();
    check("s_ready", s_ready, m_ready());
    check("wr_en", wr_en, m_wen);
    check("wr_we", wr_we, m_wen);
    check("wr_addr", wr_addr, m_addr);
    if (m_wen) check("wr_data", wr_data, m_data);
    check("frame_done", frame_done, m_done);
    check("frame_cnt", frame_cnt, m_cnt);
    check("err_short", err_short, m_es);
    check("err_long", err_long, m_el);
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit clr, output bit acc);
    @(negedge clk);
    check_outputs();
    s_valid = v; s_data = d; s_last = l; err_clr = clr;
    acc = v && m_ready();
    mdl_edge(v, d, l, clr);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, $urandom, $urandom_range(0, 1), 0, acc);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_we", wr_we, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_short", err_short, 0);
    check("rst_err_long", err_long, 0);
    mdl_reset();
    s_valid = 0; s_last = 0; err_clr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    mdl_edge(0, 0, 0, 0);
  endtask

  task automatic send(input int n, input int last_idx, input int duty, input int clr_idx,
                      input int rst_idx, input bit rnd, input logic [31:0] base);
    int i = 0, budget = 0;
    bit acc, v;
    logic [31:0] d;
    d = rnd ? $urandom : base;
    while (i < n && budget < 5000) begin
      if (i == rst_idx) begin
        #2;
        apply_reset();
        return;
      end
      v = ($urandom_range(0, 99) < duty);
      step(v, d, i == last_idx, v && i == clr_idx, acc);
      if (acc) begin
        i++;
        d = rnd ? $urandom : base + i;
      end
      budget++;
    end
    if (budget >= 5000) check("send_timeout", i, n);
  endtask

  initial begin
    bit acc;
    int len;
    #1;
    apply_reset();
    // full frame, back to back
    send(256, 255, 100, -1, -1, 0, 32'h1000);
    idle(6);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_no_err", {err_short, err_long}, 0);
    // full frame with random valid gaps
    send(256, 255, 50, -1, -1, 1, 0);
    idle(6);
    // short frame, last on index 9
    send(10, 9, 100, -1, -1, 0, 32'h3000);
    idle(260);
    check("t3_err_short", err_short, 1);
    step(0, 0, 0, 1, acc);
    idle(2);
    check("t3_err_short_clr", err_short, 0);
    // long frame: 300 words with no s_last
    send(300, -1, 100, -1, -1, 0, 32'h4000);
    idle(2);
    check("t4_err_long", err_long, 1);
    check("t4_frame_cnt", frame_cnt, 4);
    // async reset in the middle of a frame
    send(200, -1, 100, -1, 100, 0, 32'h6000);
    // err_clr in the same cycle err_long sets
    send(256, -1, 100, 255, -1, 0, 32'h5000);
    idle(2);
    check("t5_set_wins", err_long, 1);
    step(0, 0, 0, 1, acc);
    idle(2);
    check("t5_clr", err_long, 0);
    // random lengths and duty cycles
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(2, 300);
      send(len, len - 1, $urandom_range(30, 100), $urandom_range(0, 300), -1, 1, 0);
      idle($urandom_range(0, 8));
    end
    idle(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
